// File: rtl/turfio_pkg.sv
// rtl/turfio_pkg.sv - shared types and constants for the TURFIO RXCLK controller
package turfio_pkg;

    // Fine phase steps in one RXCLK period (12 VCO periods x 56 steps)
    localparam int TURFIO_PS_STEPS_PER_CYCLE = 672;

    typedef enum logic [2:0] {
        RESET_HOLD,
        WAIT_LOCK,
        LOCK_FAIL,
        IDLE,
        PS_ISSUE,
        PS_WAIT
    } rxclk_state_t;

endpackage

// File: rtl/turfio_sync_bit.sv
// rtl/turfio_sync_bit.sv - generic two-flop single-bit synchronizer
module turfio_sync_bit (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic meta;
    (* ASYNC_REG = "TRUE" *) logic sync;

    // Two back-to-back flops give a fixed two-cycle latency into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
        end
    end

    assign q = sync;

endmodule

// File: rtl/turfio_rxclk_ctrl.sv
// rtl/turfio_rxclk_ctrl.sv - RXCLK MMCM reset/lock bring-up and fine phase-shift sequencer
module turfio_rxclk_ctrl
    import turfio_pkg::*;
#(
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int PS_TIMEOUT         = 64,
    parameter int PS_STEPS_PER_CYCLE = TURFIO_PS_STEPS_PER_CYCLE,
    parameter int POS_WIDTH          = 10
) (
    input  logic                 ps_clk_i,
    input  logic                 rst_i,
    input  logic                 mmcm_rst_req_i,
    input  logic                 ps_req_i,
    input  logic [15:0]          ps_nsteps_i,
    output logic                 ps_ready_o,
    output logic                 ps_done_o,
    output logic                 mmcm_rst_o,
    input  logic                 mmcm_locked_i,
    output logic                 ps_en_o,
    input  logic                 ps_done_i,
    output logic                 locked_o,
    output logic [POS_WIDTH-1:0] ps_pos_o,
    output logic                 err_lock_timeout_o,
    output logic                 err_lock_lost_o,
    output logic                 err_ps_timeout_o
);

    localparam int RW = $clog2(RST_HOLD_CYCLES + 1);
    localparam int LW = $clog2(LOCK_TIMEOUT + 1);
    localparam int TW = $clog2(PS_TIMEOUT + 1);

    localparam logic [RW-1:0]        RST_LOAD  = RW'(RST_HOLD_CYCLES - 1);
    localparam logic [LW-1:0]        LOCK_LOAD = LW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]        PS_LOAD   = TW'(PS_TIMEOUT - 1);
    localparam logic [POS_WIDTH-1:0] POS_LAST  = POS_WIDTH'(PS_STEPS_PER_CYCLE - 1);

    rxclk_state_t         state, state_n;
    logic [RW-1:0]        rst_cnt, rst_cnt_n;
    logic [LW-1:0]        lock_cnt, lock_cnt_n;
    logic [TW-1:0]        ps_cnt, ps_cnt_n;
    logic [15:0]          remaining, remaining_n;
    logic [POS_WIDTH-1:0] ps_pos, ps_pos_n;
    logic                 err_lt, err_lt_n;
    logic                 err_ll, err_ll_n;
    logic                 err_pt, err_pt_n;
    logic                 done, done_n;
    logic                 lock_s;
    logic                 lock_region;
    logic                 shifting;

    turfio_sync_bit u_lock_sync (
        .clk (ps_clk_i),
        .rst (rst_i),
        .d   (mmcm_locked_i),
        .q   (lock_s)
    );

    assign lock_region = (state == IDLE) || (state == PS_ISSUE) || (state == PS_WAIT);
    assign shifting    = (state == PS_ISSUE) || (state == PS_WAIT);

    // State and datapath registers; rst_i restarts the full MMCM bring-up
    always_ff @(posedge ps_clk_i) begin
        if (rst_i) begin
            state     <= RESET_HOLD;
            rst_cnt   <= RST_LOAD;
            lock_cnt  <= '0;
            ps_cnt    <= '0;
            remaining <= '0;
            ps_pos    <= '0;
            err_lt    <= 1'b0;
            err_ll    <= 1'b0;
            err_pt    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            rst_cnt   <= rst_cnt_n;
            lock_cnt  <= lock_cnt_n;
            ps_cnt    <= ps_cnt_n;
            remaining <= remaining_n;
            ps_pos    <= ps_pos_n;
            err_lt    <= err_lt_n;
            err_ll    <= err_ll_n;
            err_pt    <= err_pt_n;
            done      <= done_n;
        end
    end

    // Next-state logic: MMCM reset request beats lock loss, both beat normal sequencing
    always_comb begin
        state_n     = state;
        rst_cnt_n   = rst_cnt;
        lock_cnt_n  = lock_cnt;
        ps_cnt_n    = ps_cnt;
        remaining_n = remaining;
        ps_pos_n    = ps_pos;
        err_lt_n    = err_lt;
        err_ll_n    = err_ll;
        err_pt_n    = err_pt;
        done_n      = 1'b0;

        if (mmcm_rst_req_i) begin
            state_n   = RESET_HOLD;
            rst_cnt_n = RST_LOAD;
            ps_pos_n  = '0;
            err_lt_n  = 1'b0;
            err_ll_n  = 1'b0;
            err_pt_n  = 1'b0;
            done_n    = shifting;
        end else if (lock_region && !lock_s) begin
            state_n   = RESET_HOLD;
            rst_cnt_n = RST_LOAD;
            ps_pos_n  = '0;
            err_ll_n  = 1'b1;
            done_n    = shifting;
        end else begin
            case (state)
                RESET_HOLD: begin
                    if (rst_cnt == '0) begin
                        state_n    = WAIT_LOCK;
                        lock_cnt_n = LOCK_LOAD;
                    end else begin
                        rst_cnt_n = rst_cnt - RW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_n = IDLE;
                    end else if (lock_cnt == '0) begin
                        state_n  = LOCK_FAIL;
                        err_lt_n = 1'b1;
                    end else begin
                        lock_cnt_n = lock_cnt - LW'(1);
                    end
                end
                LOCK_FAIL: begin
                    state_n = LOCK_FAIL;
                end
                IDLE: begin
                    if (ps_req_i) begin
                        remaining_n = ps_nsteps_i;
                        if (ps_nsteps_i == 16'd0) begin
                            done_n = 1'b1;
                        end else begin
                            state_n = PS_ISSUE;
                        end
                    end
                end
                PS_ISSUE: begin
                    ps_cnt_n = PS_LOAD;
                    state_n  = PS_WAIT;
                end
                PS_WAIT: begin
                    if (ps_done_i) begin
                        ps_pos_n    = (ps_pos == POS_LAST) ? '0 : ps_pos + POS_WIDTH'(1);
                        remaining_n = remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            state_n = PS_ISSUE;
                        end
                    end else if (ps_cnt == '0) begin
                        state_n  = IDLE;
                        err_pt_n = 1'b1;
                        done_n   = 1'b1;
                    end else begin
                        ps_cnt_n = ps_cnt - TW'(1);
                    end
                end
                default: begin
                    state_n   = RESET_HOLD;
                    rst_cnt_n = RST_LOAD;
                end
            endcase
        end
    end

    assign mmcm_rst_o         = (state == RESET_HOLD);
    assign ps_en_o            = (state == PS_ISSUE);
    assign ps_ready_o         = (state == IDLE) && lock_s;
    assign locked_o           = lock_region && lock_s;
    assign ps_done_o          = done;
    assign ps_pos_o           = ps_pos;
    assign err_lock_timeout_o = err_lt;
    assign err_lock_lost_o    = err_ll;
    assign err_ps_timeout_o   = err_pt;

endmodule

// File: tb/tb_turfio_rxclk_ctrl.sv
// tb/tb_turfio_rxclk_ctrl.sv - self-checking bench for turfio_rxclk_ctrl
module tb_turfio_rxclk_ctrl;

    localparam int RST_HOLD   = 4;
    localparam int LOCK_TO    = 32;
    localparam int PS_TO      = 64;
    localparam int STEPS      = 672;
    localparam int LOCK_DELAY = 10;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        mmcm_rst_req_i = 1'b0;
    logic        ps_req_i = 1'b0;
    logic [15:0] ps_nsteps_i = 16'd0;
    logic        ps_ready_o, ps_done_o, mmcm_rst_o, mmcm_locked_i, ps_en_o, ps_done_i;
    logic        locked_o, err_lock_timeout_o, err_lock_lost_o, err_ps_timeout_o;
    logic [9:0]  ps_pos_o;

    turfio_rxclk_ctrl #(
        .RST_HOLD_CYCLES    (RST_HOLD),
        .LOCK_TIMEOUT       (LOCK_TO),
        .PS_TIMEOUT         (PS_TO),
        .PS_STEPS_PER_CYCLE (STEPS),
        .POS_WIDTH          (10)
    ) dut (
        .ps_clk_i           (clk),
        .rst_i              (rst_i),
        .mmcm_rst_req_i     (mmcm_rst_req_i),
        .ps_req_i           (ps_req_i),
        .ps_nsteps_i        (ps_nsteps_i),
        .ps_ready_o         (ps_ready_o),
        .ps_done_o          (ps_done_o),
        .mmcm_rst_o         (mmcm_rst_o),
        .mmcm_locked_i      (mmcm_locked_i),
        .ps_en_o            (ps_en_o),
        .ps_done_i          (ps_done_i),
        .locked_o           (locked_o),
        .ps_pos_o           (ps_pos_o),
        .err_lock_timeout_o (err_lock_timeout_o),
        .err_lock_lost_o    (err_lock_lost_o),
        .err_ps_timeout_o   (err_ps_timeout_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int errors = 0;
    int checks = 0;
    int exp_pos = 0;

    // MMCM lock model: LOCKED rises LOCK_DELAY cycles after RST falls, gated by lock_allow
    logic locked_model = 1'b0;
    logic lock_allow = 1'b1;
    int   lk_cnt = 0;
    assign mmcm_locked_i = locked_model & lock_allow;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (mmcm_rst_o) begin
                locked_model = 1'b0;
                lk_cnt = 0;
            end else if (lk_cnt < LOCK_DELAY) begin
                lk_cnt++;
            end else begin
                locked_model = 1'b1;
            end
        end
    end

    // MMCM PSDONE model: one-cycle reply pd_lat cycles after PSEN
    int   pd_lat = 12;
    int   pd_cnt = 0;
    logic psdone_on = 1'b1;
    initial begin
        ps_done_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            ps_done_i = 1'b0;
            if (pd_cnt > 0) begin
                pd_cnt--;
                if (pd_cnt == 0) ps_done_i = 1'b1;
            end
            if (ps_en_o && psdone_on) pd_cnt = pd_lat;
        end
    end

    // Observation logs collected mid-cycle
    int   en_count = 0, en_gap = 0, en_long = 0, done_count = 0;
    int   last_pd_cyc = -10, last_en_cyc = 0, done_cyc = 0;
    int   lock_rise_cyc = 0, ready_rise_cyc = 0;
    logic prev_en = 1'b0, prev_lk = 1'b0, prev_rdy = 1'b0;
    logic [9:0] prev_pos = 10'd0;
    int   pos_log[$];
    always @(negedge clk) begin
        if (ps_en_o) begin
            en_count++;
            last_en_cyc = cyc;
            if (en_count > 1 && cyc != last_pd_cyc + 1) en_gap++;
            if (prev_en) en_long++;
        end
        if (ps_done_i) last_pd_cyc = cyc;
        if (ps_done_o) begin
            done_count++;
            done_cyc = cyc;
        end
        if (ps_pos_o != prev_pos) begin
            pos_log.push_back(int'(ps_pos_o));
            prev_pos = ps_pos_o;
        end
        if (mmcm_locked_i && !prev_lk) lock_rise_cyc = cyc;
        if (ps_ready_o && !prev_rdy) ready_rise_cyc = cyc;
        prev_en  = ps_en_o;
        prev_lk  = mmcm_locked_i;
        prev_rdy = ps_ready_o;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        en_count = 0; en_gap = 0; en_long = 0; done_count = 0;
        pos_log.delete();
    endtask

    task automatic wait_ready(input string tag);
        int b = 300;
        while (!ps_ready_o && b > 0) begin step(); b--; end
        check({tag, " ready"}, ps_ready_o, 1);
    endtask

    task automatic do_shift(input int n, input int lat, input string tag);
        int b;
        pd_lat = lat;
        clear_logs();
        check({tag, " ready before"}, ps_ready_o, 1);
        ps_nsteps_i = 16'(n);
        ps_req_i = 1'b1;
        step();
        ps_req_i = 1'b0;
        b = n * (lat + 4) + 200;
        while (!ps_done_o && b > 0) begin step(); b--; end
        check({tag, " done seen"}, ps_done_o, 1);
        exp_pos = (exp_pos + n) % STEPS;
        step(); step(); step();
        check({tag, " pos"}, ps_pos_o, exp_pos);
        check({tag, " psen pulses"}, en_count, n);
        check({tag, " psen after psdone"}, en_gap, 0);
        check({tag, " psen single cycle"}, en_long, 0);
        check({tag, " done pulses"}, done_count, 1);
        check({tag, " ready after"}, ps_ready_o, 1);
    endtask

    initial begin
        int hc, b, t;

        // Reset state and bring-up
        step(); step(); step();
        check("rst mmcm_rst", mmcm_rst_o, 1);
        check("rst psen", ps_en_o, 0);
        check("rst ready", ps_ready_o, 0);
        check("rst done", ps_done_o, 0);
        check("rst locked", locked_o, 0);
        check("rst pos", ps_pos_o, 0);
        check("rst err_lt", err_lock_timeout_o, 0);
        check("rst err_ll", err_lock_lost_o, 0);
        check("rst err_pt", err_ps_timeout_o, 0);
        rst_i = 1'b0;
        hc = 0; b = 100;
        while (mmcm_rst_o && b > 0) begin hc++; step(); b--; end
        check("bringup rst hold", hc, RST_HOLD);
        wait_ready("bringup");
        step();
        check("bringup ready latency ok", ((ready_rise_cyc - lock_rise_cyc) >= 2 &&
                                            (ready_rise_cyc - lock_rise_cyc) <= 3), 1);
        check("bringup locked", locked_o, 1);
        check("bringup pos", ps_pos_o, 0);

        // Directed shift of three, then wrap across the period boundary
        do_shift(3, 12, "shift3");
        do_shift(670 - exp_pos, $urandom_range(1, 3), "preload");
        do_shift(5, $urandom_range(1, 3), "wrap");
        check("wrap log len", pos_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < pos_log.size())
                check($sformatf("wrap pos[%0d]", i), pos_log[i], (670 + i + 1) % STEPS);
        end

        // Zero-step request
        clear_logs();
        ps_nsteps_i = 16'd0;
        ps_req_i = 1'b1;
        step();
        ps_req_i = 1'b0;
        check("zero done next", ps_done_o, 1);
        check("zero no psen", ps_en_o, 0);
        step();
        check("zero done single", ps_done_o, 0);
        step();
        check("zero psen count", en_count, 0);
        check("zero done count", done_count, 1);
        check("zero pos", ps_pos_o, exp_pos);

        // Request while busy is dropped
        clear_logs();
        pd_lat = 12;
        ps_nsteps_i = 16'd4;
        ps_req_i = 1'b1;
        step();
        ps_nsteps_i = 16'd50;
        for (int i = 0; i < 20; i++) step();
        ps_req_i = 1'b0;
        b = 200;
        while (!ps_done_o && b > 0) begin step(); b--; end
        check("busy done seen", ps_done_o, 1);
        exp_pos = (exp_pos + 4) % STEPS;
        for (int i = 0; i < 6; i++) step();
        check("busy psen count", en_count, 4);
        check("busy pos", ps_pos_o, exp_pos);

        // Random step counts and PSDONE latencies against the position model
        for (int k = 0; k < 4; k++)
            do_shift($urandom_range(1, 20), $urandom_range(1, 15), $sformatf("rand%0d", k));

        // PSDONE timeout
        clear_logs();
        psdone_on = 1'b0;
        ps_nsteps_i = 16'd3;
        ps_req_i = 1'b1;
        step();
        ps_req_i = 1'b0;
        b = 200;
        while (!ps_done_o && b > 0) begin step(); b--; end
        check("pstmo done seen", ps_done_o, 1);
        check("pstmo err", err_ps_timeout_o, 1);
        step();
        check("pstmo latency", done_cyc - last_en_cyc, PS_TO + 1);
        check("pstmo psen count", en_count, 1);
        check("pstmo pos", ps_pos_o, exp_pos);
        check("pstmo ready", ps_ready_o, 1);
        psdone_on = 1'b1;

        // Lock timeout, LOCK_FAIL is terminal until an MMCM reset request
        lock_allow = 1'b0;
        mmcm_rst_req_i = 1'b1;
        step();
        mmcm_rst_req_i = 1'b0;
        exp_pos = 0;
        check("locktmo err_pt cleared", err_ps_timeout_o, 0);
        check("locktmo rst high", mmcm_rst_o, 1);
        t = 0; b = 200;
        while (!err_lock_timeout_o && b > 0) begin step(); t++; b--; end
        check("locktmo cycle", t, RST_HOLD + LOCK_TO);
        lock_allow = 1'b1;
        for (int i = 0; i < 30; i++) step();
        check("lockfail stays", ps_ready_o, 0);
        check("lockfail rst low", mmcm_rst_o, 0);
        check("lockfail err", err_lock_timeout_o, 1);
        check("lockfail locked_o", locked_o, 0);
        mmcm_rst_req_i = 1'b1;
        step();
        mmcm_rst_req_i = 1'b0;
        wait_ready("relock");
        check("relock err_lt cleared", err_lock_timeout_o, 0);
        check("relock pos", ps_pos_o, 0);

        // Lock loss in the middle of a ten-step shift
        do_shift(7, 5, "pre-loss");
        clear_logs();
        pd_lat = 12;
        ps_nsteps_i = 16'd10;
        ps_req_i = 1'b1;
        step();
        ps_req_i = 1'b0;
        b = 300;
        while (en_count < 4 && b > 0) begin step(); b--; end
        step(); step();
        lock_allow = 1'b0;
        b = 50;
        while (!ps_done_o && b > 0) begin step(); b--; end
        check("loss done seen", ps_done_o, 1);
        lock_allow = 1'b1;
        exp_pos = 0;
        hc = 0; b = 100;
        while (mmcm_rst_o && b > 0) begin hc++; step(); b--; end
        check("loss rst hold", hc, RST_HOLD);
        check("loss err_ll", err_lock_lost_o, 1);
        wait_ready("loss relock");
        check("loss done count", done_count, 1);
        check("loss pos", ps_pos_o, exp_pos);
        check("loss err_ll kept", err_lock_lost_o, 1);
        check("loss locked_o", locked_o, 1);
        mmcm_rst_req_i = 1'b1;
        step();
        mmcm_rst_req_i = 1'b0;
        check("req clears err_ll", err_lock_lost_o, 0);
        wait_ready("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
